// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: debounce FSM encoding
// and the default stability window for a 100 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE         = 2'd0,
        BTN_PRESS_WAIT   = 2'd1,
        BTN_HELD         = 2'd2,
        BTN_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms of stable samples at 100 MHz
    localparam int BTN_DEBOUNCE_100MHZ = 1000000;
    localparam int BTN_CNT_W           = 20;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter and a four-state
// debounce FSM producing a registered level and a one-cycle press pulse.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_100MHZ,
    parameter int CNT_W           = BTN_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic level_next,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    btn_state_t       state;
    logic             cnt_done;

    assign cnt_done = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Level the FSM will present after the coming edge; lets the top register
    // its move outputs on the same edge the level changes.
    always_comb begin
        level_next = 1'b0;
        case (state)
            BTN_IDLE:         level_next = 1'b0;
            BTN_PRESS_WAIT:   level_next = sync_q2 & cnt_done;
            BTN_HELD:         level_next = 1'b1;
            BTN_RELEASE_WAIT: level_next = sync_q2 | ~cnt_done;
            default:          level_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BTN_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                BTN_IDLE: begin
                    if (sync_q2) begin
                        state <= BTN_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                BTN_PRESS_WAIT: begin
                    if (!sync_q2) begin
                        state <= BTN_IDLE;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= BTN_HELD;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BTN_HELD: begin
                    if (!sync_q2) begin
                        state <= BTN_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                BTN_RELEASE_WAIT: begin
                    if (sync_q2) begin
                        state <= BTN_HELD;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state <= BTN_IDLE;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= BTN_IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Two debounced button channels plus registered, mutually exclusive paddle
// move commands so up and down are never asserted together.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_100MHZ,
    parameter int CNT_W           = BTN_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btnUpRaw,
    input  logic btnDownRaw,
    output logic upLevel,
    output logic downLevel,
    output logic upPress,
    output logic downPress,
    output logic moveUp,
    output logic moveDown
);

    logic up_next;
    logic down_next;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clk       (clk),
        .reset     (reset),
        .raw       (btnUpRaw),
        .level     (upLevel),
        .level_next(up_next),
        .press     (upPress)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clk       (clk),
        .reset     (reset),
        .raw       (btnDownRaw),
        .level     (downLevel),
        .level_next(down_next),
        .press     (downPress)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            moveUp   <= 1'b0;
            moveDown <= 1'b0;
        end else begin
            moveUp   <= up_next & ~down_next;
            moveDown <= down_next & ~up_next;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=8 (latency 11 edges).
module tb_btn_conditioner;

    localparam int DB  = 8;
    localparam int LAT = DB + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btnUpRaw = 1'b0;
    logic btnDownRaw = 1'b0;
    logic upLevel, downLevel, upPress, downPress, moveUp, moveDown;

    int total = 0;
    int bad = 0;
    int up_cnt = 0;
    int dn_cnt = 0;
    logic saw_level;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btnUpRaw  (btnUpRaw),
        .btnDownRaw(btnDownRaw),
        .upLevel   (upLevel),
        .downLevel (downLevel),
        .upPress   (upPress),
        .downPress (downPress),
        .moveUp    (moveUp),
        .moveDown  (moveDown)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit; inputs are driven and outputs
    // sampled here, away from the edge. Press pulses are tallied per edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            up_cnt += int'(upPress);
            dn_cnt += int'(downPress);
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_upLevel"},   upLevel,   1'b0);
        chk({tag, "_downLevel"}, downLevel, 1'b0);
        chk({tag, "_upPress"},   upPress,   1'b0);
        chk({tag, "_downPress"}, downPress, 1'b0);
        chk({tag, "_moveUp"},    moveUp,    1'b0);
        chk({tag, "_moveDown"},  moveDown,  1'b0);
    endtask

    initial begin
        // 1. Reset with both buttons held
        btnUpRaw   = 1'b1;
        btnDownRaw = 1'b1;
        #1;
        chk_all_zero("rst_t0");
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_all_zero("rst_hold");
        end
        reset  = 1'b0;
        up_cnt = 0;
        dn_cnt = 0;
        tick(LAT - 1);
        chk("rst_up_early", upLevel, 1'b0);
        chk("rst_dn_early", downLevel, 1'b0);
        tick(1);
        chk("rst_up_level", upLevel, 1'b1);
        chk("rst_dn_level", downLevel, 1'b1);
        chk("rst_up_press", upPress, 1'b1);
        chk("rst_dn_press", downPress, 1'b1);
        chk("rst_both_moveUp", moveUp, 1'b0);
        chk("rst_both_moveDown", moveDown, 1'b0);
        tick(3);
        chk_n("rst_up_pulses", up_cnt, 1);
        chk_n("rst_dn_pulses", dn_cnt, 1);

        // release both simultaneously
        btnUpRaw   = 1'b0;
        btnDownRaw = 1'b0;
        tick(LAT - 1);
        chk("rel_both_up_held", upLevel, 1'b1);
        tick(1);
        chk("rel_both_up", upLevel, 1'b0);
        chk("rel_both_dn", downLevel, 1'b0);
        chk("rel_both_moveUp", moveUp, 1'b0);
        chk("rel_both_moveDown", moveDown, 1'b0);
        tick(4);

        // 2. Clean press
        up_cnt   = 0;
        btnUpRaw = 1'b1;
        tick(LAT - 1);
        chk("clean_level_early", upLevel, 1'b0);
        chk("clean_press_early", upPress, 1'b0);
        chk("clean_move_early", moveUp, 1'b0);
        tick(1);
        chk("clean_level", upLevel, 1'b1);
        chk("clean_press", upPress, 1'b1);
        chk("clean_moveUp", moveUp, 1'b1);
        chk("clean_moveDown", moveDown, 1'b0);
        tick(1);
        chk("clean_press_1cyc", upPress, 1'b0);
        chk("clean_level_hold", upLevel, 1'b1);
        tick(30 - LAT - 1);
        btnUpRaw = 1'b0;
        tick(LAT);
        chk("clean_release", upLevel, 1'b0);
        chk("clean_release_move", moveUp, 1'b0);
        chk_n("clean_pulses", up_cnt, 1);
        tick(4);

        // 3. Bounce: toggle every 3 cycles for 40 cycles, then settle high
        up_cnt    = 0;
        saw_level = 1'b0;
        for (int i = 0; i < 40; i++) begin
            btnUpRaw = ((i / 3) % 2 == 0);
            tick(1);
            saw_level |= upLevel;
        end
        chk("bounce_no_level", saw_level, 1'b0);
        chk_n("bounce_no_pulse", up_cnt, 0);
        btnUpRaw = 1'b1;
        tick(LAT - 1);
        chk("bounce_level_early", upLevel, 1'b0);
        tick(1);
        chk("bounce_level", upLevel, 1'b1);
        chk("bounce_press", upPress, 1'b1);
        tick(2);
        chk_n("bounce_pulses", up_cnt, 1);

        // 4. Release glitch of 5 cycles is rejected
        up_cnt    = 0;
        saw_level = 1'b1;
        btnUpRaw  = 1'b0;
        tick(5);
        saw_level &= upLevel;
        btnUpRaw  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            saw_level &= upLevel;
        end
        chk("glitch_level_kept", saw_level, 1'b1);
        chk_n("glitch_no_pulse", up_cnt, 0);
        // a 12-cycle drop is accepted, then the re-press follows directly
        btnUpRaw = 1'b0;
        tick(LAT - 1);
        chk("drop_level_early", upLevel, 1'b1);
        tick(1);
        chk("drop_level", upLevel, 1'b0);
        tick(1);
        btnUpRaw = 1'b1;
        tick(LAT - 1);
        chk("repress_early", upLevel, 1'b0);
        tick(1);
        chk("repress_level", upLevel, 1'b1);
        chk_n("repress_pulses", up_cnt, 1);

        // 5. Both buttons: up held, then down pressed
        dn_cnt     = 0;
        btnDownRaw = 1'b1;
        tick(LAT - 1);
        chk("both_moveUp_before", moveUp, 1'b1);
        chk("both_dn_early", downLevel, 1'b0);
        tick(1);
        chk("both_dn_level", downLevel, 1'b1);
        chk("both_dn_press", downPress, 1'b1);
        chk("both_moveUp", moveUp, 1'b0);
        chk("both_moveDown", moveDown, 1'b0);
        tick(5);
        btnUpRaw = 1'b0;
        tick(LAT - 1);
        chk("both_up_still", upLevel, 1'b1);
        chk("both_moveDown_before", moveDown, 1'b0);
        tick(1);
        chk("both_up_fall", upLevel, 1'b0);
        chk("both_moveDown_after", moveDown, 1'b1);
        chk("both_moveUp_after", moveUp, 1'b0);
        btnDownRaw = 1'b0;
        tick(LAT);
        chk("both_dn_release", downLevel, 1'b0);
        chk("both_moveDown_end", moveDown, 1'b0);
        chk_n("both_dn_pulses", dn_cnt, 1);
        tick(4);

        // 6. Reset pulse while PRESS_WAIT holds count 4
        btnUpRaw = 1'b1;
        tick(7);
        up_cnt = 0;
        reset  = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick(1);
        chk("midrst_level_hold", upLevel, 1'b0);
        reset = 1'b0;
        tick(LAT - 1);
        chk("midrst_level_early", upLevel, 1'b0);
        chk_n("midrst_no_pulse", up_cnt, 0);
        tick(1);
        chk("midrst_level", upLevel, 1'b1);
        chk("midrst_press", upPress, 1'b1);
        tick(2);
        chk_n("midrst_pulses", up_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
